// File: rtl/nc_no_contact_monitor.sv
// Debouncer and fault monitor for NC/NO dry-contact pairs.
// Each pair is synchronised, decoded, debounced on a prescaled tick, and reported via sticky latches and one irq.
module nc_no_contact_monitor #(
    parameter int unsigned N_CH        = 8,
    parameter int unsigned TICK_DIV    = 100,
    parameter int unsigned DEB_TICKS   = 10,
    parameter int unsigned FAULT_TICKS = 50
) (
    input  logic            clk_100m,
    input  logic            rst_syn,
    input  logic [N_CH-1:0] nc,
    input  logic [N_CH-1:0] no,
    input  logic [N_CH-1:0] ch_en,
    input  logic [N_CH-1:0] clr_change,
    input  logic [N_CH-1:0] clr_fault,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] valid,
    output logic [N_CH-1:0] fault_act,
    output logic [N_CH-1:0] change_lat,
    output logic [N_CH-1:0] fault_lat,
    output logic            irq
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = $clog2(FAULT_TICKS + 1);

    typedef enum logic [1:0] {DEC_INV, DEC_REL, DEC_PRS} dec_t;
    typedef enum logic [1:0] {ST_UNKNOWN, ST_RELEASED, ST_PRESSED, ST_FAULT} state_t;

    logic [N_CH-1:0] nc_s1, nc_s2, no_s1, no_s2;
    dec_t            dec_cur  [N_CH];
    dec_t            dec_prev [N_CH];
    logic [CW-1:0]   cnt      [N_CH];
    logic [PW-1:0]   presc;
    logic            tick;
    state_t          state    [N_CH];
    state_t          state_nx [N_CH];
    logic [N_CH-1:0] set_change, set_fault;

    // Two-flop synchronisers on the raw contacts
    always_ff @(posedge clk_100m) begin
        if (rst_syn) begin
            nc_s1 <= '0;
            nc_s2 <= '0;
            no_s1 <= '0;
            no_s2 <= '0;
        end else begin
            nc_s1 <= nc;
            nc_s2 <= nc_s1;
            no_s1 <= no;
            no_s2 <= no_s1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            dec_cur[i] = DEC_INV;
            if (nc_s2[i] && !no_s2[i]) begin
                dec_cur[i] = DEC_REL;
            end else if (!nc_s2[i] && no_s2[i]) begin
                dec_cur[i] = DEC_PRS;
            end
        end
    end

    // Debounce tick prescaler; tick is high for the cycle in which the count is back at 0
    always_ff @(posedge clk_100m) begin
        if (rst_syn) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= (presc == PW'(TICK_DIV - 1));
            if (presc == PW'(TICK_DIV - 1)) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Per-channel previous decode and saturating stability counter
    always_ff @(posedge clk_100m) begin
        if (rst_syn) begin
            for (int i = 0; i < N_CH; i++) begin
                dec_prev[i] <= DEC_INV;
                cnt[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                dec_prev[i] <= dec_cur[i];
                if (!ch_en[i] || (dec_cur[i] != dec_prev[i])) begin
                    cnt[i] <= '0;
                end else if (tick && (cnt[i] != CW'(FAULT_TICKS))) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_100m) begin
        if (rst_syn) begin
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= ST_UNKNOWN;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= state_nx[i];
            end
        end
    end

    // Next state and latch set events; a disabled channel is frozen
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_nx[i]   = state[i];
            set_change[i] = 1'b0;
            set_fault[i]  = 1'b0;
            if (ch_en[i]) begin
                if ((dec_prev[i] == DEC_REL) && (cnt[i] >= CW'(DEB_TICKS))) begin
                    state_nx[i] = ST_RELEASED;
                end else if ((dec_prev[i] == DEC_PRS) && (cnt[i] >= CW'(DEB_TICKS))) begin
                    state_nx[i] = ST_PRESSED;
                end else if ((dec_prev[i] == DEC_INV) && (cnt[i] == CW'(FAULT_TICKS))) begin
                    state_nx[i] = ST_FAULT;
                end
            end
            if ((state_nx[i] != state[i]) && (state[i] != ST_FAULT) &&
                ((state_nx[i] == ST_RELEASED) || (state_nx[i] == ST_PRESSED))) begin
                set_change[i] = 1'b1;
            end
            if ((state_nx[i] == ST_FAULT) && (state[i] != ST_FAULT)) begin
                set_fault[i] = 1'b1;
            end
        end
    end

    // Registered outputs track the next state so they change with it; set beats clear
    always_ff @(posedge clk_100m) begin
        if (rst_syn) begin
            pressed    <= '0;
            valid      <= '0;
            fault_act  <= '0;
            change_lat <= '0;
            fault_lat  <= '0;
            irq        <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                pressed[i]   <= (state_nx[i] == ST_PRESSED);
                valid[i]     <= (state_nx[i] == ST_PRESSED) || (state_nx[i] == ST_RELEASED);
                fault_act[i] <= (state_nx[i] == ST_FAULT);
            end
            change_lat <= (change_lat & ~clr_change) | set_change;
            fault_lat  <= (fault_lat & ~clr_fault) | set_fault;
            irq        <= |((change_lat | fault_lat) & ch_en);
        end
    end

endmodule

// File: tb/tb_nc_no_contact_monitor.sv
// Directed bench for nc_no_contact_monitor: debounce, bounce rejection, fault, latches, irq masking, reset.
module tb_nc_no_contact_monitor;
    localparam int unsigned N_CH        = 4;
    localparam int unsigned TICK_DIV    = 4;
    localparam int unsigned DEB_TICKS   = 3;
    localparam int unsigned FAULT_TICKS = 8;

    logic            clk_100m = 1'b0;
    logic            rst_syn;
    logic [N_CH-1:0] nc, no, ch_en, clr_change, clr_fault;
    logic [N_CH-1:0] pressed, valid, fault_act, change_lat, fault_lat;
    logic            irq;

    int         checks = 0;
    int         errors = 0;
    int         n;
    logic       glitch;
    logic       changed;
    logic [19:0] snap;

    always #5 clk_100m = ~clk_100m;

    nc_no_contact_monitor #(
        .N_CH       (N_CH),
        .TICK_DIV   (TICK_DIV),
        .DEB_TICKS  (DEB_TICKS),
        .FAULT_TICKS(FAULT_TICKS)
    ) dut (
        .clk_100m  (clk_100m),
        .rst_syn   (rst_syn),
        .nc        (nc),
        .no        (no),
        .ch_en     (ch_en),
        .clr_change(clr_change),
        .clr_fault (clr_fault),
        .pressed   (pressed),
        .valid     (valid),
        .fault_act (fault_act),
        .change_lat(change_lat),
        .fault_lat (fault_lat),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int cyc = 1);
        repeat (cyc) begin
            @(posedge clk_100m);
            #1;
        end
    endtask

    initial begin
        rst_syn = 1'b1; nc = '0; no = '0; ch_en = '0; clr_change = '0; clr_fault = '0;
        step(3);
        check("rst_outputs", 32'({pressed, valid, fault_act, change_lat, fault_lat, irq}), 0);

        // 1: ch0 released, first exit from UNKNOWN
        nc = 4'hF; no = 4'h0; ch_en = 4'b0001; rst_syn = 1'b0;
        n = 0;
        while (!valid[0] && n < 40) begin step(); n++; end
        check("t1_latency", 32'(n >= 12 && n <= 19), 1);
        check("t1_pressed0", 32'(pressed[0]), 0);
        check("t1_change_lat", 32'(change_lat), 4'b0001);
        check("t1_irq_not_yet", 32'(irq), 0);
        step();
        check("t1_irq", 32'(irq), 1);
        clr_change = 4'b0001; step(); clr_change = '0;
        check("t1_change_clr", 32'(change_lat[0]), 0);
        step();
        check("t1_irq_clr", 32'(irq), 0);

        // 2: ch1 settles released, then a press with a 2-tick bounce back to REL
        ch_en = 4'b0011;
        n = 0;
        while (!valid[1] && n < 40) begin step(); n++; end
        check("t2_rel_settle", 32'(valid[1]), 1);
        clr_change = 4'b0010; step(); clr_change = '0; step(2);
        glitch = 1'b0;
        nc[1] = 1'b0; no[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin step(); if (pressed[1] || !valid[1]) glitch = 1'b1; end
        nc[1] = 1'b1; no[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin step(); if (pressed[1] || !valid[1]) glitch = 1'b1; end
        nc[1] = 1'b0; no[1] = 1'b1;
        n = 0;
        while (!pressed[1] && n < 40) begin step(); n++; end
        check("t2_no_glitch", 32'(glitch), 0);
        check("t2_latency", 32'(n >= 12 && n <= 19), 1);
        check("t2_change_lat1", 32'(change_lat[1]), 1);
        check("t2_valid1", 32'(valid[1]), 1);
        clr_change = 4'b0010; step(); clr_change = '0; step(2);

        // 3: ch2 stuck INV faults, recovers, fault latch is sticky until cleared
        ch_en = 4'b0111;
        n = 0;
        while (!valid[2] && n < 40) begin step(); n++; end
        check("t3_rel_settle", 32'(valid[2]), 1);
        clr_change = 4'b0100; step(); clr_change = '0; step(2);
        no[2] = 1'b1;
        step(28);
        check("t3_no_early_fault", 32'(fault_act[2]), 0);
        step(12);
        check("t3_fault_act", 32'(fault_act[2]), 1);
        check("t3_fault_lat", 32'(fault_lat), 4'b0100);
        check("t3_valid_low", 32'(valid[2]), 0);
        check("t3_no_change_on_fault", 32'(change_lat[2]), 0);
        step();
        check("t3_irq", 32'(irq), 1);
        no[2] = 1'b0;
        n = 0;
        while (fault_act[2] && n < 40) begin step(); n++; end
        check("t3_recover_latency", 32'(n >= 12 && n <= 19), 1);
        check("t3_valid_back", 32'(valid[2]), 1);
        check("t3_no_change_on_exit", 32'(change_lat[2]), 0);
        check("t3_fault_lat_sticky", 32'(fault_lat[2]), 1);
        clr_fault = 4'b0100; step(); clr_fault = '0;
        check("t3_fault_clr", 32'(fault_lat[2]), 0);
        step();
        check("t3_irq_clr", 32'(irq), 0);

        // 4: 5-tick INV pulse on pressed ch1 changes nothing
        snap = {pressed, valid, fault_act, change_lat, fault_lat};
        changed = 1'b0;
        nc[1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if ({pressed, valid, fault_act, change_lat, fault_lat} !== snap) changed = 1'b1;
        end
        nc[1] = 1'b0;
        for (int k = 0; k < 24; k++) begin
            step();
            if ({pressed, valid, fault_act, change_lat, fault_lat} !== snap) changed = 1'b1;
        end
        check("t4_no_change", 32'(changed), 0);
        check("t4_still_pressed", 32'(pressed[1]), 1);
        check("t4_irq", 32'(irq), 0);

        // 5a: clear held across the set cycle; set wins
        clr_change = 4'b0001;
        nc[0] = 1'b0; no[0] = 1'b1;
        n = 0;
        while (!pressed[0] && n < 40) begin step(); n++; end
        clr_change = '0;
        check("t5_pressed0", 32'(pressed[0]), 1);
        check("t5_set_wins", 32'(change_lat[0]), 1);
        step();
        check("t5_set_kept", 32'(change_lat[0]), 1);
        clr_change = 4'b0001; step(); clr_change = '0; step(2);

        // 5b: disabling ch3 masks its latch from irq
        ch_en = 4'b1111;
        n = 0;
        while (!valid[3] && n < 40) begin step(); n++; end
        step();
        check("t5_irq_ch3", 32'(irq), 1);
        ch_en = 4'b0111; step();
        check("t5_irq_masked", 32'(irq), 0);
        check("t5_lat_kept", 32'(change_lat[3]), 1);
        check("t5_frozen_valid", 32'(valid[3]), 1);
        ch_en = 4'b1111; step();
        check("t5_irq_unmasked", 32'(irq), 1);

        // 5c: reset in the middle of a debounce
        nc[3] = 1'b0; no[3] = 1'b1;
        step(6);
        rst_syn = 1'b1; step();
        check("t5_reset_outputs", 32'({pressed, valid, fault_act, change_lat, fault_lat, irq}), 0);
        rst_syn = 1'b0;
        step(10);
        check("t5_no_partial_valid", 32'(valid), 0);
        check("t5_no_partial_irq", 32'(irq), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
